// File: rtl/x_mem_arbiter.sv
// rtl/x_mem_arbiter.sv - two-requester memory arbiter with alternating priority and grant timeout
//
// Purpose: shares one downstream memory port between two requesters.  An
// idle cycle always separates grants; on a tie the requester that was not
// granted last wins.  A granted request that waits P_TIMEOUT cycles for the
// downstream completion is completed locally with an error.
//
// Ports:
//   i_clk, i_nrst              clock, asynchronous active-low reset
//   i_rN_valid/rnw/addr/data   requester N request (N = 0,1)
//   o_rN_accept, o_rN_data     requester N completion pulse and read data
//   o_m_valid/rnw/addr/data    downstream request
//   i_m_accept, i_m_data       downstream completion and read data
//   o_err, o_err_src           timeout pulse and last timed-out requester
module x_mem_arbiter #(
  parameter int unsigned P_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_r0_valid,
  input  logic        i_r0_rnw,
  input  logic [31:0] i_r0_addr,
  input  logic [31:0] i_r0_data,
  output logic        o_r0_accept,
  output logic [31:0] o_r0_data,
  input  logic        i_r1_valid,
  input  logic        i_r1_rnw,
  input  logic [31:0] i_r1_addr,
  input  logic [31:0] i_r1_data,
  output logic        o_r1_accept,
  output logic [31:0] o_r1_data,
  output logic        o_m_valid,
  output logic        o_m_rnw,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_data,
  input  logic        i_m_accept,
  input  logic [31:0] i_m_data,
  output logic        o_err,
  output logic        o_err_src
);

  localparam logic [7:0]  LP_TIMEOUT = 8'(P_TIMEOUT);
  localparam logic [31:0] LP_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT0 = 2'd1,
    S_GRANT1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_src_q, err_src_d;

  logic        gnt_idx;
  logic        sel_valid;
  logic        sel_rnw;
  logic [31:0] sel_addr;
  logic [31:0] sel_data;
  logic        acc;
  logic [31:0] acc_data;
  logic        timeout_hit;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      cnt_q     <= 8'd0;
      err_src_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      err_src_q <= err_src_d;
    end
  end

  // Requester currently owning the downstream port (only meaningful in a grant state).
  always_comb begin
    gnt_idx   = (state_q == S_GRANT1);
    sel_valid = gnt_idx ? i_r1_valid : i_r0_valid;
    sel_rnw   = gnt_idx ? i_r1_rnw   : i_r0_rnw;
    sel_addr  = gnt_idx ? i_r1_addr  : i_r0_addr;
    sel_data  = gnt_idx ? i_r1_data  : i_r0_data;
  end

  // A timeout of zero never matches, so the counter alone cannot end a grant.
  assign timeout_hit = (LP_TIMEOUT != 8'd0) && (cnt_q == LP_TIMEOUT);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    err_src_d = err_src_q;
    o_m_valid = 1'b0;
    o_m_rnw   = 1'b0;
    o_m_addr  = 32'd0;
    o_m_data  = 32'd0;
    o_err     = 1'b0;
    acc       = 1'b0;
    acc_data  = 32'd0;

    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (i_r0_valid && i_r1_valid) begin
          // Tie: favour whoever was not granted last.
          if (last_q) begin
            state_d = S_GRANT0;
            last_d  = 1'b0;
          end else begin
            state_d = S_GRANT1;
            last_d  = 1'b1;
          end
        end else if (i_r0_valid) begin
          state_d = S_GRANT0;
          last_d  = 1'b0;
        end else if (i_r1_valid) begin
          state_d = S_GRANT1;
          last_d  = 1'b1;
        end
      end

      S_GRANT0, S_GRANT1: begin
        o_m_valid = sel_valid;
        o_m_rnw   = sel_rnw;
        o_m_addr  = sel_addr;
        o_m_data  = sel_data;
        if (!sel_valid) begin
          // Requester withdrew: drop the grant quietly.
          state_d = S_IDLE;
        end else if (i_m_accept) begin
          // Downstream completion takes precedence over a coincident timeout.
          acc      = 1'b1;
          acc_data = i_m_data;
          state_d  = S_IDLE;
        end else if (timeout_hit) begin
          o_m_valid = 1'b0;
          o_err     = 1'b1;
          acc       = 1'b1;
          acc_data  = LP_ERR_DATA;
          err_src_d = gnt_idx;
          state_d   = S_IDLE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    o_r0_accept = acc & ~gnt_idx;
    o_r1_accept = acc &  gnt_idx;
    o_r0_data   = (acc & ~gnt_idx) ? acc_data : 32'd0;
    o_r1_data   = (acc &  gnt_idx) ? acc_data : 32'd0;
  end

  assign o_err_src = err_src_q;

endmodule

// File: tb/tb_x_mem_arbiter.sv
// tb/tb_x_mem_arbiter.sv - scoreboard testbench for x_mem_arbiter
module tb_x_mem_arbiter;

  logic        clk;
  logic        nrst;
  logic        r0_valid, r0_rnw, r1_valid, r1_rnw;
  logic [31:0] r0_addr, r0_data, r1_addr, r1_data;
  logic        r0_accept, r1_accept;
  logic [31:0] r0_rdata, r1_rdata;
  logic        m_valid, m_rnw, m_accept;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        err, err_src;

  typedef struct packed {
    logic        src;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk;
  int   n_fail;
  int   n_push;
  int   acc_seen;

  x_mem_arbiter #(.P_TIMEOUT(4)) dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_r0_valid  (r0_valid),
    .i_r0_rnw    (r0_rnw),
    .i_r0_addr   (r0_addr),
    .i_r0_data   (r0_data),
    .o_r0_accept (r0_accept),
    .o_r0_data   (r0_rdata),
    .i_r1_valid  (r1_valid),
    .i_r1_rnw    (r1_rnw),
    .i_r1_addr   (r1_addr),
    .i_r1_data   (r1_data),
    .o_r1_accept (r1_accept),
    .o_r1_data   (r1_rdata),
    .o_m_valid   (m_valid),
    .o_m_rnw     (m_rnw),
    .o_m_addr    (m_addr),
    .o_m_data    (m_wdata),
    .i_m_accept  (m_accept),
    .i_m_data    (m_rdata),
    .o_err       (err),
    .o_err_src   (err_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic src, input logic [31:0] d, input logic e);
    exp_t x;
    x.src  = src;
    x.data = d;
    x.err  = e;
    exp_q.push_back(x);
    n_push++;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: every completion pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (err && !(r0_accept || r1_accept)) chk("err_without_accept", 32'(err), 32'd0);
    if (r0_accept || r1_accept) begin
      acc_seen++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_accept: got r0=%0b r1=%0b expected none", r0_accept, r1_accept);
      end else begin
        mon_e = exp_q.pop_front();
        chk("acc_r1", 32'(r1_accept), 32'(mon_e.src));
        chk("acc_r0", 32'(r0_accept), 32'(!mon_e.src));
        chk("acc_data", mon_e.src ? r1_rdata : r0_rdata, mon_e.data);
        chk("acc_err", 32'(err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    n_chk = 0; n_fail = 0; n_push = 0; acc_seen = 0;
    nrst = 1'b1;
    r0_valid = 0; r0_rnw = 0; r0_addr = 0; r0_data = 0;
    r1_valid = 0; r1_rnw = 0; r1_addr = 0; r1_data = 0;
    m_accept = 0; m_rdata = 0;
    #1 nrst = 1'b0;

    // Reset state
    mid();
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_accept", 32'({r0_accept, r1_accept}), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_src", 32'(err_src), 0);
    nxt();
    nrst = 1'b1;

    // Single r0 read, accepted on third grant cycle
    r0_valid = 1; r0_rnw = 1; r0_addr = 32'h100;
    mid();
    chk("t1_idle_mvalid", 32'(m_valid), 0);
    nxt();
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin
        m_accept = 1; m_rdata = 32'h1234_5678;
        push(1'b0, 32'h1234_5678, 1'b0);
      end
      mid();
      chk("t1_mvalid", 32'(m_valid), 1);
      chk("t1_maddr", m_addr, 32'h100);
      chk("t1_mrnw", 32'(m_rnw), 1);
      chk("t1_r1_accept", 32'(r1_accept), 0);
      chk("t1_r1_data", r1_rdata, 0);
      nxt();
    end
    m_accept = 0; r0_valid = 0;
    mid();
    chk("t1_after_mvalid", 32'(m_valid), 0);
    nxt();

    // Both valid from reset: strict alternation, r0 first
    nrst = 0;
    r0_valid = 1; r0_addr = 32'hA0; r1_valid = 1; r1_addr = 32'hB0;
    nxt();
    nrst = 1; m_accept = 1;
    push(1'b0, 32'hC000_0001, 1'b0);
    push(1'b1, 32'hC000_0003, 1'b0);
    push(1'b0, 32'hC000_0005, 1'b0);
    push(1'b1, 32'hC000_0007, 1'b0);
    for (int k = 0; k < 8; k++) begin
      m_rdata = 32'hC000_0000 + 32'(k);
      mid();
      chk("t2_accept_slot", 32'(r0_accept | r1_accept), 32'(k % 2));
      if (k % 2 == 1) chk("t2_maddr", m_addr, (k % 4 == 1) ? 32'hA0 : 32'hB0);
      nxt();
    end
    r0_valid = 0; r1_valid = 0; m_accept = 0;

    // r1 write timing out after four wait cycles
    r1_valid = 1; r1_rnw = 0; r1_addr = 32'h200; r1_data = 32'h55;
    push(1'b1, 32'hDEAD_BEEF, 1'b1);
    for (int k = 0; k <= 5; k++) begin
      mid();
      chk("t3_err", 32'(err), 32'(k == 5));
      chk("t3_mvalid", 32'(m_valid), 32'(k >= 1 && k <= 4));
      if (k == 1) chk("t3_mdata", m_wdata, 32'h55);
      nxt();
    end
    r1_valid = 0;
    mid();
    chk("t3_err_src", 32'(err_src), 1);
    chk("t3_err_clear", 32'(err), 0);
    nxt();

    // Accept coincident with timeout: accept wins
    r0_valid = 1; r0_rnw = 1; r0_addr = 32'h300;
    push(1'b0, 32'hA5A5_A5A5, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      m_accept = (k == 5);
      m_rdata  = (k == 5) ? 32'hA5A5_A5A5 : 32'd0;
      mid();
      chk("t4_err", 32'(err), 0);
      chk("t4_mvalid", 32'(m_valid), 32'(k >= 1));
      nxt();
    end
    r0_valid = 0; m_accept = 0;
    mid();
    chk("t4_err_src_hold", 32'(err_src), 1);
    nxt();

    // r0 withdraws mid-grant; pending r1 served next
    r0_valid = 1; r0_addr = 32'h400;
    mid(); nxt();
    r1_valid = 1; r1_addr = 32'h500;
    mid();
    chk("t5_g0_mvalid", 32'(m_valid), 1);
    nxt();
    r0_valid = 0;
    mid();
    chk("t5_drop_mvalid", 32'(m_valid), 0);
    chk("t5_drop_err", 32'(err), 0);
    chk("t5_drop_accept", 32'(r0_accept), 0);
    nxt();
    mid();
    chk("t5_idle_mvalid", 32'(m_valid), 0);
    nxt();
    m_accept = 1; m_rdata = 32'h77;
    push(1'b1, 32'h77, 1'b0);
    mid();
    chk("t5_g1_mvalid", 32'(m_valid), 1);
    chk("t5_g1_maddr", m_addr, 32'h500);
    nxt();
    r1_valid = 0; m_accept = 0;
    mid(); nxt();

    // Reset pulse during GRANT0 with r1 pending
    r0_valid = 1; r0_addr = 32'h600;
    mid(); nxt();
    r1_valid = 1; r1_addr = 32'h700;
    mid();
    chk("t6_g0_mvalid", 32'(m_valid), 1);
    nxt();
    nrst = 0; m_accept = 1; m_rdata = 32'h99;
    mid();
    chk("t6_rst_mvalid", 32'(m_valid), 0);
    chk("t6_rst_maddr", m_addr, 0);
    chk("t6_rst_accept", 32'(r0_accept), 0);
    chk("t6_rst_r0data", r0_rdata, 0);
    chk("t6_rst_err_src", 32'(err_src), 0);
    nxt();
    nrst = 1; m_accept = 0;
    mid();
    chk("t6_idle_mvalid", 32'(m_valid), 0);
    nxt();
    m_accept = 1; m_rdata = 32'h88;
    push(1'b0, 32'h88, 1'b0);
    mid();
    chk("t6_first_maddr", m_addr, 32'h600);
    nxt();
    r0_valid = 0; r1_valid = 0; m_accept = 0;
    mid(); nxt();
    mid(); nxt();

    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("accept_count", 32'(acc_seen), 32'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
